pwm_multi_ctrl: RTL and testbench

//  Multi-channel PWM generator with per-channel duty stepped by debounced inc/dec buttons.

---
 rtl/pwm_multi_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pwm_multi_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ctrl.sv
// pwm_multi_ctrl
//   Multi-channel PWM generator. Each channel's duty is stepped up or down by a
//   debounced inc/dec button pair. Period, mode and duty are double-buffered and
//   only change at a period boundary, so a running period is never glitched.
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   en         run enable; 0 holds the counter and drives the outputs low
//   mode       0 = edge-aligned, 1 = centre-aligned (applied at the next boundary)
//   period     requested period in counts; values below 2 are treated as 2
//   inc, dec   raw increase/decrease buttons, one per channel
//   pwm_out    registered PWM outputs, one per channel
//   duty_o     active duty per channel; channel i = duty_o[i*CW +: CW]
//   cyc_start  one-clock pulse in the first cycle of every period
module pwm_multi_ctrl #(
  parameter int CH         = 4,
  parameter int CW         = 8,
  parameter int PERIOD_DEF = 10,
  parameter int DUTY_RST   = 5,
  parameter int STEP       = 1,
  parameter int DEB_DIV    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [CW-1:0]    period,
  input  logic [CH-1:0]    inc,
  input  logic [CH-1:0]    dec,
  output logic [CH-1:0]    pwm_out,
  output logic [CH*CW-1:0] duty_o,
  output logic             cyc_start
);

  localparam int             DW        = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST  = DW'(DEB_DIV - 1);
  localparam logic [CW-1:0]  PER_RST   = CW'(PERIOD_DEF);
  localparam logic [CW-1:0]  DUTY_INIT = (DUTY_RST > PERIOD_DEF) ? CW'(PERIOD_DEF) : CW'(DUTY_RST);
  localparam logic [CW:0]    STEP_X    = (CW+1)'(STEP);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [DW-1:0] div;
  logic          tick;
  logic [CH-1:0] inc_s1, inc_s2, dec_s1, dec_s2;
  logic [CH-1:0] inc_p, dec_p;

  logic [CW-1:0] cnt, cnt_nxt;
  dir_t          dir, dir_nxt;
  logic [CW-1:0] per_act, per_req;
  logic          mode_act;
  logic          en_q;
  logic          run;
  logic          boundary;
  logic [CH-1:0] raw;

  logic [CW-1:0] tgt      [CH];
  logic [CW-1:0] duty_act [CH];
  logic [CW-1:0] tgt_step [CH];
  logic [CW-1:0] tgt_nxt  [CH];
  logic [CW-1:0] duty_nxt [CH];
  logic [CW:0]   tgt_sum  [CH];
  logic [CW-1:0] tgt_clmp [CH];

  // Debounce: two flops sampled on the divided tick; a press is a clean 0->1.
  always_comb begin
    tick  = (div == DIV_LAST);
    inc_p = inc_s1 & ~inc_s2 & {CH{tick}};
    dec_p = dec_s1 & ~dec_s2 & {CH{tick}};
  end

  // Counter/direction state machine and boundary detection.
  always_comb begin
    per_req  = (period < CW'(2)) ? CW'(2) : period;
    run      = en & en_q;
    boundary = 1'b0;
    if (en) begin
      if (!en_q)
        boundary = 1'b1;
      else if (!mode_act)
        boundary = (cnt == per_act - CW'(1));
      else
        boundary = (cnt == '0) && (dir == DIR_DOWN);
    end

    cnt_nxt = cnt;
    dir_nxt = dir;
    if (!en || boundary) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (!mode_act) begin
      cnt_nxt = cnt + CW'(1);
    end else if (dir == DIR_UP) begin
      // Peak value is held for one extra clock while turning around.
      if (cnt == per_act - CW'(1))
        dir_nxt = DIR_DOWN;
      else
        cnt_nxt = cnt + CW'(1);
    end else begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  // The first enabled cycle only loads the buffers; output starts with cnt=0 after it.
  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (!mode_act)
        raw[i] = run && (cnt < duty_act[i]);
      else
        raw[i] = run && (cnt >= per_act - duty_act[i]);
    end
  end

  // Per-channel target update, then boundary clamp against the incoming period.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      tgt_sum[i]  = {1'b0, tgt[i]} + STEP_X;
      tgt_step[i] = tgt[i];
      if (inc_p[i] && !dec_p[i])
        tgt_step[i] = (tgt_sum[i] > {1'b0, per_act}) ? per_act : tgt_sum[i][CW-1:0];
      else if (dec_p[i] && !inc_p[i])
        tgt_step[i] = ({1'b0, tgt[i]} >= STEP_X) ? tgt[i] - STEP_X[CW-1:0] : '0;

      tgt_clmp[i] = (tgt_step[i] > per_req) ? per_req : tgt_step[i];
      tgt_nxt[i]  = tgt_step[i];
      duty_nxt[i] = duty_act[i];
      if (boundary) begin
        tgt_nxt[i]  = tgt_clmp[i];
        duty_nxt[i] = tgt_clmp[i];
      end
    end
  end

  always_comb begin
    duty_o = '0;
    for (int unsigned i = 0; i < CH; i++)
      duty_o[i*CW +: CW] = duty_act[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      inc_s1    <= '0;
      inc_s2    <= '0;
      dec_s1    <= '0;
      dec_s2    <= '0;
      cnt       <= '0;
      dir       <= DIR_UP;
      per_act   <= PER_RST;
      mode_act  <= 1'b0;
      en_q      <= 1'b0;
      pwm_out   <= '0;
      cyc_start <= 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
        tgt[i]      <= DUTY_INIT;
        duty_act[i] <= DUTY_INIT;
      end
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        inc_s1 <= inc;
        inc_s2 <= inc_s1;
        dec_s1 <= dec;
        dec_s2 <= dec_s1;
      end
      en_q <= en;
      cnt  <= cnt_nxt;
      dir  <= dir_nxt;
      if (boundary) begin
        per_act  <= per_req;
        mode_act <= mode;
      end
      pwm_out   <= raw;
      cyc_start <= boundary;
      for (int unsigned i = 0; i < CH; i++) begin
        tgt[i]      <= tgt_nxt[i];
        duty_act[i] <= duty_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Testbench for pwm_multi_ctrl: directed stimulus pushes one expected record per
// PWM period; a monitor measures each period between cyc_start pulses and checks it.
module tb_pwm_multi_ctrl;
  localparam int CH = 4;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             rst, en, mode;
  logic [CW-1:0]    period;
  logic [CH-1:0]    inc, dec;
  logic [CH-1:0]    pwm_out;
  logic [CH*CW-1:0] duty_o;
  logic             cyc_start;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [CH*CW-1:0] duty;
    logic [7:0]       len;
    logic [CH*8-1:0]  high;
    logic [CH-1:0]    mask;
  } win_t;

  win_t exp_q[$];

  pwm_multi_ctrl #(
    .CH(CH), .CW(CW), .PERIOD_DEF(10), .DUTY_RST(5), .STEP(1), .DEB_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period),
    .inc(inc), .dec(dec), .pwm_out(pwm_out), .duty_o(duty_o), .cyc_start(cyc_start)
  );

  always #5 clk = ~clk;

  function automatic logic [CH*CW-1:0] pack4(input int d0, input int d1, input int d2, input int d3);
    return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
  endfunction

  function automatic win_t mk(input int len, input int d0, input int d1, input int d2, input int d3,
                              input int h0, input int h1, input int h2, input int h3,
                              input logic [CH-1:0] m);
    win_t w;
    w.duty = pack4(d0, d1, d2, d3);
    w.len  = 8'(len);
    w.high = {8'(h3), 8'(h2), 8'(h1), 8'(h0)};
    w.mask = m;
    return w;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cs();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!cyc_start && n < 100);
    if (!cyc_start) begin
      tests++;
      fails++;
      $display("FAIL wait_cs: no cyc_start within %0d clk, required one", n);
    end
  endtask

  task automatic press(input logic [CH-1:0] i_m, input logic [CH-1:0] d_m);
    inc = i_m;
    dec = d_m;
    step(12);
    inc = '0;
    dec = '0;
    step(12);
  endtask

  // Monitor: a window covers the pwm_out samples from the clock after one
  // cyc_start up to and including the next one (one-clock output latency).
  bit               mon_on = 1'b0;
  int               mon_len;
  int               mon_high [CH];
  logic [CH*CW-1:0] mon_duty;
  logic [CH*CW-1:0] mon_dm;
  win_t             mon_e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_on) begin
        mon_len++;
        for (int c = 0; c < CH; c++) mon_high[c] += int'(pwm_out[c]);
      end
      if (cyc_start) begin
        if (mon_on) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL window: got unexpected period end, required none");
          end else begin
            mon_e = exp_q.pop_front();
            for (int c = 0; c < CH; c++) mon_dm[c*CW +: CW] = mon_e.mask[c] ? '1 : '0;
            check("duty_o", longint'(mon_duty & mon_dm), longint'(mon_e.duty & mon_dm));
            check("period_len", mon_len, int'(mon_e.len));
            for (int c = 0; c < CH; c++)
              if (mon_e.mask[c])
                check($sformatf("high_ch%0d", c), mon_high[c], int'(mon_e.high[c*8 +: 8]));
          end
        end
        mon_on   = 1'b1;
        mon_len  = 0;
        for (int c = 0; c < CH; c++) mon_high[c] = 0;
        mon_duty = duty_o;
      end
      if (rst || !en) mon_on = 1'b0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1; en = 1'b0; mode = 1'b0; period = 8'd10; inc = '0; dec = '0;
    step(3);
    check("rst_pwm", pwm_out, 0);
    check("rst_cyc_start", cyc_start, 0);
    check("rst_duty", duty_o, pack4(5, 5, 5, 5));
    rst = 1'b0;
    en  = 1'b1;

    // Basic edge-aligned operation, period 10, duty 5
    wait_cs();
    exp_q.push_back(mk(10, 5, 5, 5, 5, 5, 5, 5, 5, '1));
    wait_cs();
    exp_q.push_back(mk(10, 5, 5, 5, 5, 5, 5, 5, 5, '1));
    check("lat_cnt9", pwm_out[0], 0);
    step(5);
    check("lat_cnt4", pwm_out[0], 1);
    step(1);
    check("lat_cnt5", pwm_out[0], 0);
    wait_cs();

    // Held inc[1] for 40 clk: exactly one step, applied at the next boundary
    inc = 4'b0010;
    exp_q.push_back(mk(10, 5, 5, 5, 5, 5, 5, 5, 5, '1));
    wait_cs();
    repeat (3) begin
      exp_q.push_back(mk(10, 5, 6, 5, 5, 5, 6, 5, 5, '1));
      wait_cs();
    end
    inc = '0;

    // Saturation high and low on ch0 (targets move while disabled)
    en = 1'b0;
    repeat (10) press(4'b0001, 4'b0000);
    en = 1'b1;
    wait_cs();
    exp_q.push_back(mk(10, 10, 6, 5, 5, 10, 6, 5, 5, '1));
    wait_cs();
    en = 1'b0;
    repeat (12) press(4'b0000, 4'b0001);
    en = 1'b1;
    wait_cs();
    exp_q.push_back(mk(10, 0, 6, 5, 5, 0, 6, 5, 5, '1));
    wait_cs();
    en = 1'b0;

    // Simultaneous inc/dec on ch2 holds; press at cnt=3 waits for the boundary
    press(4'b0100, 4'b0100);
    en = 1'b1;
    wait_cs();
    exp_q.push_back(mk(10, 0, 6, 5, 5, 0, 6, 5, 5, '1));
    wait_cs();
    step(3);
    inc = 4'b1000;
    exp_q.push_back(mk(10, 0, 6, 5, 5, 0, 6, 5, 5, '1));
    wait_cs();
    exp_q.push_back(mk(10, 0, 6, 5, 0, 0, 6, 5, 0, 4'b0111));
    step(5);
    inc = '0;
    wait_cs();
    exp_q.push_back(mk(10, 0, 6, 5, 6, 0, 6, 5, 6, '1));
    wait_cs();

    // Mode switch at cnt=4 completes the edge period, then centre periods of 20
    step(4);
    mode = 1'b1;
    exp_q.push_back(mk(10, 0, 6, 5, 6, 0, 6, 5, 6, '1));
    wait_cs();
    exp_q.push_back(mk(20, 0, 6, 5, 6, 0, 12, 10, 12, '1));
    wait_cs();
    exp_q.push_back(mk(20, 0, 6, 5, 6, 0, 12, 10, 12, '1));
    wait_cs();
    en   = 1'b0;
    mode = 1'b0;

    // ch2 to 8, then period 6 mid-period clamps duty to 6 at the boundary
    repeat (3) press(4'b0100, 4'b0000);
    en = 1'b1;
    wait_cs();
    exp_q.push_back(mk(10, 0, 6, 8, 6, 0, 6, 8, 6, '1));
    wait_cs();
    step(4);
    period = 8'd6;
    exp_q.push_back(mk(10, 0, 6, 8, 6, 0, 6, 8, 6, '1));
    wait_cs();
    exp_q.push_back(mk(6, 0, 6, 6, 6, 0, 6, 6, 6, '1));
    wait_cs();

    // Reset mid-period
    step(2);
    rst = 1'b1;
    step(1);
    check("midrst_pwm", pwm_out, 0);
    check("midrst_cyc_start", cyc_start, 0);
    check("midrst_duty", duty_o, pack4(5, 5, 5, 5));
    rst = 1'b0;
    wait_cs();
    exp_q.push_back(mk(6, 5, 5, 5, 5, 5, 5, 5, 5, '1));
    wait_cs();

    // Period request below 2 acts as 2; duty clamps to 2
    step(1);
    period = 8'd0;
    exp_q.push_back(mk(6, 5, 5, 5, 5, 5, 5, 5, 5, '1));
    wait_cs();
    exp_q.push_back(mk(2, 2, 2, 2, 2, 2, 2, 2, 2, '1));
    wait_cs();
    exp_q.push_back(mk(2, 2, 2, 2, 2, 2, 2, 2, 2, '1));
    wait_cs();
    en = 1'b0;
    step(4);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
